// File: rtl/cpu_bus_responder_if.sv
// cpu_bus_responder_if: CPU-side request bus plus external system bus.
// The slave modport belongs to the responder. The master modport belongs to the
// CPU and memory environment that drives requests and returns external read data.
interface cpu_bus_responder_if;
    logic        m_cycle;
    logic        cpu_mem_enable;
    logic        cpu_mem_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_rd;
    logic        ext_wr;

    modport slave (
        output m_cycle,
        input  cpu_mem_enable,
        input  cpu_mem_write,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_rdata,
        output ext_addr,
        output ext_wdata,
        input  ext_rdata,
        output ext_rd,
        output ext_wr
    );

    modport master (
        input  m_cycle,
        output cpu_mem_enable,
        output cpu_mem_write,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_rdata,
        input  ext_addr,
        input  ext_wdata,
        output ext_rdata,
        input  ext_rd,
        input  ext_wr
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: memory-side responder for the CPU M-cycle bus.
// It generates m_cycle and latches one request per M-cycle at the phase-0 edge.
// HRAM requests are served locally. All other requests go to the external bus.
// Optional OAM DMA engine: define CPU_BUS_OAM_DMA_EN. When it is undefined, FF46 is
// an ordinary external address.
module cpu_bus_responder #(
    parameter logic [15:0] HRAM_BASE = 16'hFF80
) (
    input  logic               clk_i,
    input  logic               reset_i,
    cpu_bus_responder_if.slave bus_io
);
    // HRAM spans HRAM_BASE..FFFE. FFFF (IE) always stays external.
    localparam int unsigned HramDepth = 32'(16'hFFFF - HRAM_BASE);
    localparam int unsigned HramAw    = $clog2(HramDepth);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLocalRd = 3'd1;
    localparam logic [2:0] StLocalWr = 3'd2;
    localparam logic [2:0] StExtRd   = 3'd3;
    localparam logic [2:0] StExtWr   = 3'd4;

    function automatic logic in_hram(input logic [15:0] addr);
        return (addr >= HRAM_BASE) && (addr != 16'hFFFF);
    endfunction

    logic [1:0]  phase_q, phase_d;
    logic [2:0]  state_q, state_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [7:0]  req_wdata_q, req_wdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic        ext_rd_q, ext_rd_d;
    logic        ext_wr_q, ext_wr_d;

    logic [7:0]        hram_q [HramDepth];
    logic [HramAw-1:0] hram_idx;
    logic [7:0]        hram_rd;
    logic              hram_we;
    logic              req_hit;
    logic              local_sel;
    logic [2:0]        dec_state;
    logic [7:0]        local_rdata;

`ifdef CPU_BUS_OAM_DMA_EN
    localparam logic [15:0] DmaRegAddr = 16'hFF46;
    localparam logic [7:0]  DmaLast    = 8'd159;

    logic [7:0] dma_src_q, dma_src_d;
    logic [7:0] dma_idx_q, dma_idx_d;
    logic       dma_active_q, dma_active_d;
    // High for the whole M-cycle in which a DMA byte is being moved.
    logic       dma_cycle_q, dma_cycle_d;
    logic       dma_reg_we;
`endif

    assign req_hit  = in_hram(req_addr_q);
    assign hram_idx = HramAw'(req_addr_q - HRAM_BASE);
    assign hram_rd  = hram_q[hram_idx];
    assign hram_we  = !reset_i && (phase_q == 2'd2) && (state_q == StLocalWr) && req_hit;

`ifdef CPU_BUS_OAM_DMA_EN
    assign dma_reg_we = (phase_q == 2'd2) && (state_q == StLocalWr) &&
                        (req_addr_q == DmaRegAddr);
`endif

    // Decide how the request presented during phase 0 will be served.
    always_comb begin
        local_sel = in_hram(bus_io.cpu_addr);
`ifdef CPU_BUS_OAM_DMA_EN
        // While DMA owns the external bus, every CPU access is kept internal.
        local_sel = local_sel || dma_active_q || (bus_io.cpu_addr == DmaRegAddr);
`endif
        dec_state = StIdle;
        if (bus_io.cpu_mem_enable) begin
            if (local_sel) begin
                dec_state = bus_io.cpu_mem_write ? StLocalWr : StLocalRd;
            end else begin
                dec_state = bus_io.cpu_mem_write ? StExtWr : StExtRd;
            end
        end
    end

    // Select read data for requests that are not forwarded externally.
    always_comb begin
`ifdef CPU_BUS_OAM_DMA_EN
        if (req_hit) begin
            local_rdata = hram_rd;
        end else if (req_addr_q == DmaRegAddr) begin
            local_rdata = dma_src_q;
        end else begin
            local_rdata = 8'hFF;
        end
`else
        local_rdata = hram_rd;
`endif
    end

    // Next-state logic for the phase counter, the request FSM and the bus outputs.
    always_comb begin
        phase_d     = phase_q + 2'd1;
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_rd_d    = ext_rd_q;
        ext_wr_d    = ext_wr_q;
`ifdef CPU_BUS_OAM_DMA_EN
        dma_src_d    = dma_src_q;
        dma_idx_d    = dma_idx_q;
        dma_active_d = dma_active_q;
        dma_cycle_d  = dma_cycle_q;
`endif
        case (phase_q)
            2'd0: begin
                state_d     = dec_state;
                req_addr_d  = bus_io.cpu_addr;
                req_wdata_d = bus_io.cpu_wdata;
                if ((dec_state == StExtRd) || (dec_state == StExtWr)) begin
                    ext_addr_d  = bus_io.cpu_addr;
                    ext_wdata_d = bus_io.cpu_wdata;
                    ext_rd_d    = (dec_state == StExtRd);
                end
            end
            2'd1: begin
                if (state_q == StExtWr) begin
                    ext_wr_d = 1'b1;
                end
`ifdef CPU_BUS_OAM_DMA_EN
                // Source byte is taken here and becomes the OAM write data.
                if (dma_cycle_q) begin
                    ext_rd_d    = 1'b0;
                    ext_wr_d    = 1'b1;
                    ext_addr_d  = {8'hFE, dma_idx_q};
                    ext_wdata_d = bus_io.ext_rdata;
                end
`endif
            end
            2'd2: begin
                ext_rd_d = 1'b0;
                ext_wr_d = 1'b0;
                if (state_q == StExtRd) begin
                    cpu_rdata_d = bus_io.ext_rdata;
                end else if (state_q == StLocalRd) begin
                    cpu_rdata_d = local_rdata;
                end
`ifdef CPU_BUS_OAM_DMA_EN
                if (dma_cycle_q) begin
                    dma_idx_d = dma_idx_q + 8'd1;
                    if (dma_idx_q == DmaLast) begin
                        dma_active_d = 1'b0;
                    end
                end
                // A write to FF46 starts or restarts the copy from index 0.
                if (dma_reg_we) begin
                    dma_src_d    = req_wdata_q;
                    dma_idx_d    = 8'd0;
                    dma_active_d = 1'b1;
                end
`endif
            end
            default: begin
`ifdef CPU_BUS_OAM_DMA_EN
                // The DMA read strobe must already be up in phase 0.
                dma_cycle_d = dma_active_q;
                if (dma_active_q) begin
                    ext_rd_d   = 1'b1;
                    ext_addr_d = {dma_src_q, dma_idx_q};
                end
`endif
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q     <= 2'd0;
            state_q     <= StIdle;
            req_addr_q  <= 16'h0000;
            req_wdata_q <= 8'h00;
            cpu_rdata_q <= 8'hFF;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 8'h00;
            ext_rd_q    <= 1'b0;
            ext_wr_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_rd_q    <= ext_rd_d;
            ext_wr_q    <= ext_wr_d;
        end
    end

`ifdef CPU_BUS_OAM_DMA_EN
    // DMA engine registers. Reset aborts any copy in progress.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dma_src_q    <= 8'h00;
            dma_idx_q    <= 8'd0;
            dma_active_q <= 1'b0;
            dma_cycle_q  <= 1'b0;
        end else begin
            dma_src_q    <= dma_src_d;
            dma_idx_q    <= dma_idx_d;
            dma_active_q <= dma_active_d;
            dma_cycle_q  <= dma_cycle_d;
        end
    end
`endif

    // HRAM storage. It has no reset, and a write is dropped if reset lands on its edge.
    always_ff @(posedge clk_i) begin
        if (hram_we) begin
            hram_q[hram_idx] <= req_wdata_q;
        end
    end

    assign bus_io.m_cycle   = (phase_q == 2'd3);
    assign bus_io.cpu_rdata = cpu_rdata_q;
    assign bus_io.ext_addr  = ext_addr_q;
    assign bus_io.ext_wdata = ext_wdata_q;
    assign bus_io.ext_rd    = ext_rd_q;
    assign bus_io.ext_wr    = ext_wr_q;
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed self-checking bench for cpu_bus_responder.
// The DMA scenarios run only when CPU_BUS_OAM_DMA_EN is defined.
module tb_cpu_bus_responder;
    // Strobe patterns for phases 3..0. Each phase is packed as {ext_rd, ext_wr, m_cycle}.
    localparam logic [11:0] PatLocal = 12'b001_000_000_000;
    localparam logic [11:0] PatExtRd = 12'b001_100_100_000;
    localparam logic [11:0] PatExtWr = 12'b001_010_000_000;
    localparam logic [11:0] PatDma   = 12'b001_010_100_100;

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  ext;
        logic [11:0] pat;
        logic        chk_rd;
        logic [7:0]  exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic        mem_model;
    logic [7:0]  ext_data;
    logic        obs_rd [4];
    logic        obs_wr [4];
    logic        obs_mc [4];
    logic [15:0] obs_addr [4];
    logic [7:0]  obs_wdata [4];
    logic [7:0]  obs_rdata;

    cpu_bus_responder_if bus ();

    cpu_bus_responder #(
        .HRAM_BASE(16'hFF80)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    assign bus.ext_rdata = mem_model ? src_byte(bus.ext_addr) : ext_data;

    function automatic logic [2:0] strobes(input int p);
        return {obs_rd[p], obs_wr[p], obs_mc[p]};
    endfunction

    // Run one M-cycle. Call it #1 after the edge that enters phase 0.
    task automatic run_mcycle(input logic en, input logic wr, input logic [15:0] addr,
                              input logic [7:0] wdata);
        bus.cpu_mem_enable = en;
        bus.cpu_mem_write  = wr;
        bus.cpu_addr       = addr;
        bus.cpu_wdata      = wdata;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            obs_rd[p]    = bus.ext_rd;
            obs_wr[p]    = bus.ext_wr;
            obs_mc[p]    = bus.m_cycle;
            obs_addr[p]  = bus.ext_addr;
            obs_wdata[p] = bus.ext_wdata;
            if (p == 3) obs_rdata = bus.cpu_rdata;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks += 5;
                if (bus.cpu_rdata !== 8'hFF) begin
                    errors++; $display("FAIL reset cpu_rdata got %h want ff", bus.cpu_rdata);
                end
                if (bus.ext_addr !== 16'h0000) begin
                    errors++; $display("FAIL reset ext_addr got %h want 0000", bus.ext_addr);
                end
                if (bus.ext_wdata !== 8'h00) begin
                    errors++; $display("FAIL reset ext_wdata got %h want 00", bus.ext_wdata);
                end
                if (bus.ext_rd !== 1'b0) begin
                    errors++; $display("FAIL reset ext_rd got %b want 0", bus.ext_rd);
                end
                if (bus.ext_wr !== 1'b0) begin
                    errors++; $display("FAIL reset ext_wr got %b want 0", bus.ext_wr);
                end
            end
            checks++;
            if (bus.m_cycle !== (k == 4)) begin
                errors++;
                $display("FAIL reset m_cycle clk %0d got %b want %b", k, bus.m_cycle, k == 4);
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_ext_read();
        logic [11:0] pat;
        pat = PatExtRd;
        ext_data = 8'h5A;
        run_mcycle(1'b1, 1'b0, 16'hC123, 8'h00);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (strobes(p) !== pat[p*3 +: 3]) begin
                errors++;
                $display("FAIL ext_read strobes ph%0d got %b want %b", p, strobes(p), pat[p*3 +: 3]);
            end
        end
        for (int p = 1; p <= 2; p++) begin
            checks++;
            if (obs_addr[p] !== 16'hC123) begin
                errors++; $display("FAIL ext_read ext_addr ph%0d got %h want c123", p, obs_addr[p]);
            end
        end
        checks++;
        if (obs_rdata !== 8'h5A) begin
            errors++; $display("FAIL ext_read cpu_rdata got %h want 5a", obs_rdata);
        end
    endtask

    task automatic test_ext_write();
        logic [11:0] pat;
        pat = PatExtWr;
        ext_data = 8'h77;
        run_mcycle(1'b1, 1'b1, 16'hC000, 8'h3C);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (strobes(p) !== pat[p*3 +: 3]) begin
                errors++;
                $display("FAIL ext_write strobes ph%0d got %b want %b", p, strobes(p), pat[p*3 +: 3]);
            end
        end
        checks += 3;
        if (obs_addr[2] !== 16'hC000) begin
            errors++; $display("FAIL ext_write ext_addr got %h want c000", obs_addr[2]);
        end
        if (obs_wdata[2] !== 8'h3C) begin
            errors++; $display("FAIL ext_write ext_wdata got %h want 3c", obs_wdata[2]);
        end
        if (obs_rdata !== 8'h5A) begin
            errors++; $display("FAIL ext_write cpu_rdata held got %h want 5a", obs_rdata);
        end
    endtask

    task automatic test_hram();
        vec_t        v [7];
        logic [11:0] pat;
        v[0] = '{1'b1, 1'b1, 16'hFF80, 8'hA5, 8'h00, PatLocal, 1'b0, 8'h00};
        v[1] = '{1'b1, 1'b1, 16'hFFFE, 8'hC3, 8'h00, PatLocal, 1'b0, 8'h00};
        v[2] = '{1'b1, 1'b0, 16'hFF80, 8'h00, 8'h00, PatLocal, 1'b1, 8'hA5};
        v[3] = '{1'b1, 1'b0, 16'hFFFE, 8'h00, 8'h00, PatLocal, 1'b1, 8'hC3};
        v[4] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'hE7, PatExtRd, 1'b1, 8'hE7};
        v[5] = '{1'b1, 1'b0, 16'hFF7F, 8'h00, 8'h12, PatExtRd, 1'b1, 8'h12};
        v[6] = '{1'b0, 1'b0, 16'hFF80, 8'h00, 8'h34, PatLocal, 1'b1, 8'h12};
        for (int k = 0; k < 7; k++) begin
            ext_data = v[k].ext;
            pat = v[k].pat;
            run_mcycle(v[k].en, v[k].wr, v[k].addr, v[k].wdata);
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (strobes(p) !== pat[p*3 +: 3]) begin
                    errors++;
                    $display("FAIL hram row%0d strobes ph%0d got %b want %b", k, p, strobes(p),
                             pat[p*3 +: 3]);
                end
            end
            if (pat[7]) begin
                checks++;
                if (obs_addr[2] !== v[k].addr) begin
                    errors++;
                    $display("FAIL hram row%0d ext_addr got %h want %h", k, obs_addr[2], v[k].addr);
                end
            end
            if (v[k].chk_rd) begin
                checks++;
                if (obs_rdata !== v[k].exp_rd) begin
                    errors++;
                    $display("FAIL hram row%0d cpu_rdata got %h want %h", k, obs_rdata, v[k].exp_rd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t        v [5];
        logic [11:0] pat;
        v[0] = '{1'b1, 1'b0, 16'hD000, 8'h00, 8'h99, PatExtRd, 1'b1, 8'h99};
        v[1] = '{1'b1, 1'b0, 16'hD001, 8'h00, 8'h66, PatExtRd, 1'b1, 8'h66};
        v[2] = '{1'b1, 1'b1, 16'hD002, 8'h44, 8'h55, PatExtWr, 1'b1, 8'h66};
        v[3] = '{1'b1, 1'b0, 16'hFF80, 8'h00, 8'h55, PatLocal, 1'b1, 8'hA5};
        v[4] = '{1'b1, 1'b0, 16'hD003, 8'h00, 8'h3E, PatExtRd, 1'b1, 8'h3E};
        for (int k = 0; k < 5; k++) begin
            ext_data = v[k].ext;
            pat = v[k].pat;
            run_mcycle(v[k].en, v[k].wr, v[k].addr, v[k].wdata);
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (strobes(p) !== pat[p*3 +: 3]) begin
                    errors++;
                    $display("FAIL b2b row%0d strobes ph%0d got %b want %b", k, p, strobes(p),
                             pat[p*3 +: 3]);
                end
            end
            if (pat[7] || pat[4]) begin
                checks++;
                if (obs_addr[2] !== v[k].addr) begin
                    errors++;
                    $display("FAIL b2b row%0d ext_addr got %h want %h", k, obs_addr[2], v[k].addr);
                end
            end
            if (v[k].wr && pat[7]) begin
                checks++;
                if (obs_wdata[2] !== v[k].wdata) begin
                    errors++;
                    $display("FAIL b2b row%0d ext_wdata got %h want %h", k, obs_wdata[2],
                             v[k].wdata);
                end
            end
            checks++;
            if (obs_rdata !== v[k].exp_rd) begin
                errors++;
                $display("FAIL b2b row%0d cpu_rdata got %h want %h", k, obs_rdata, v[k].exp_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Reset is asserted during phase 1 of an external write.
        bus.cpu_mem_enable = 1'b1;
        bus.cpu_mem_write  = 1'b1;
        bus.cpu_addr       = 16'hC000;
        bus.cpu_wdata      = 8'h3C;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ext_wr !== 1'b0) begin
            errors++; $display("FAIL reset_mid ext_wr ph1 got %b want 0", bus.ext_wr);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks += 5;
        if (bus.ext_wr !== 1'b0) begin
            errors++; $display("FAIL reset_mid ext_wr got %b want 0", bus.ext_wr);
        end
        if (bus.ext_rd !== 1'b0) begin
            errors++; $display("FAIL reset_mid ext_rd got %b want 0", bus.ext_rd);
        end
        if (bus.ext_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_mid ext_addr got %h want 0000", bus.ext_addr);
        end
        if (bus.ext_wdata !== 8'h00) begin
            errors++; $display("FAIL reset_mid ext_wdata got %h want 00", bus.ext_wdata);
        end
        if (bus.cpu_rdata !== 8'hFF) begin
            errors++; $display("FAIL reset_mid cpu_rdata got %h want ff", bus.cpu_rdata);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.cpu_mem_enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks += 2;
            if (bus.m_cycle !== (k == 4)) begin
                errors++;
                $display("FAIL reset_mid m_cycle clk %0d got %b want %b", k, bus.m_cycle, k == 4);
            end
            if (bus.ext_wr !== 1'b0) begin
                errors++; $display("FAIL reset_mid late ext_wr clk %0d got %b want 0", k, bus.ext_wr);
            end
            @(posedge clk);
        end
        #1;
        // Reset on the HRAM commit edge must discard the write.
        run_mcycle(1'b1, 1'b1, 16'hFF81, 8'h11);
        bus.cpu_mem_enable = 1'b1;
        bus.cpu_mem_write  = 1'b1;
        bus.cpu_addr       = 16'hFF81;
        bus.cpu_wdata      = 8'h5B;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.cpu_mem_enable = 1'b0;
        run_mcycle(1'b1, 1'b0, 16'hFF81, 8'h00);
        checks++;
        if (obs_rdata !== 8'h11) begin
            errors++; $display("FAIL reset_mid hram abort got %h want 11", obs_rdata);
        end
    endtask

`ifdef CPU_BUS_OAM_DMA_EN
    task automatic test_dma(input logic restart);
        logic [11:0] pat;
        logic [7:0]  src;
        logic [7:0]  idx;
        logic        en;
        logic        wr;
        logic        chk;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        int          ncyc;
        mem_model = 1'b1;
        ncyc = restart ? 211 : 160;
        run_mcycle(1'b1, 1'b1, 16'hFF46, 8'hC1);
        for (int n = 0; n < ncyc; n++) begin
            src = (restart && n > 50) ? 8'hC2 : 8'hC1;
            idx = (restart && n > 50) ? 8'(n - 51) : 8'(n);
            en = 1'b0; wr = 1'b0; addr = 16'h0000; wd = 8'h00; chk = 1'b0; exp_rd = 8'h00;
            if (!restart && n == 10) begin en = 1'b1; addr = 16'hC000; chk = 1'b1; exp_rd = 8'hFF; end
            if (!restart && n == 20) begin en = 1'b1; addr = 16'hFF80; chk = 1'b1; exp_rd = 8'hA5; end
            if (!restart && n == 30) begin en = 1'b1; addr = 16'hFF46; chk = 1'b1; exp_rd = 8'hC1; end
            if (restart && n == 50) begin en = 1'b1; wr = 1'b1; addr = 16'hFF46; wd = 8'hC2; end
            run_mcycle(en, wr, addr, wd);
            pat = PatDma;
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (strobes(p) !== pat[p*3 +: 3]) begin
                    errors++;
                    $display("FAIL dma cyc%0d strobes ph%0d got %b want %b", n, p, strobes(p),
                             pat[p*3 +: 3]);
                end
            end
            checks += 3;
            if (obs_addr[0] !== {src, idx}) begin
                errors++; $display("FAIL dma cyc%0d src addr got %h want %h", n, obs_addr[0], {src, idx});
            end
            if (obs_addr[2] !== {8'hFE, idx}) begin
                errors++; $display("FAIL dma cyc%0d dst addr got %h want %h", n, obs_addr[2], {8'hFE, idx});
            end
            if (obs_wdata[2] !== src_byte({src, idx})) begin
                errors++;
                $display("FAIL dma cyc%0d data got %h want %h", n, obs_wdata[2], src_byte({src, idx}));
            end
            if (chk) begin
                checks++;
                if (obs_rdata !== exp_rd) begin
                    errors++; $display("FAIL dma cyc%0d cpu_rdata got %h want %h", n, obs_rdata, exp_rd);
                end
            end
        end
        // The copy is finished, so the next M-cycle reads FF46 without bus traffic.
        run_mcycle(1'b1, 1'b0, 16'hFF46, 8'h00);
        pat = PatLocal;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (strobes(p) !== pat[p*3 +: 3]) begin
                errors++;
                $display("FAIL dma done strobes ph%0d got %b want %b", p, strobes(p), pat[p*3 +: 3]);
            end
        end
        checks++;
        if (obs_rdata !== (restart ? 8'hC2 : 8'hC1)) begin
            errors++; $display("FAIL dma reg readback got %h", obs_rdata);
        end
        run_mcycle(1'b1, 1'b0, 16'hC000, 8'h00);
        checks++;
        if (obs_rdata !== 8'hC0) begin
            errors++; $display("FAIL dma post ext read got %h want c0", obs_rdata);
        end
        mem_model = 1'b0;
    endtask
`endif

    initial begin
        reset              = 1'b1;
        mem_model          = 1'b0;
        ext_data           = 8'h00;
        bus.cpu_mem_enable = 1'b0;
        bus.cpu_mem_write  = 1'b0;
        bus.cpu_addr       = 16'h0000;
        bus.cpu_wdata      = 8'h00;
        test_reset();
        test_ext_read();
        test_ext_write();
        test_hram();
        test_back_to_back();
        test_reset_mid();
`ifdef CPU_BUS_OAM_DMA_EN
        test_dma(1'b0);
        test_dma(1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
